keypad_entry: RTL and testbench
===============================

// Module: keypad_entry
// PURPOSE
//  Input-side counterpart to the 8-digit SSD scanner: scans a 4x4 matrix keypad (drives columns, reads rows),
//  debounces, decodes keys, accumulates decimal digits into a 16-bit binary value.
//  entry_value feeds the display's 16-bit number input live; a committed value is handed to the game logic.
// PARAMETERS
//  SCAN_BITS      18  column dwell = 2**SCAN_BITS clk cycles; one full scan = 4 dwells
//  DEBOUNCE_SCANS 4   consecutive identical full scans needed to accept a press or a release
//  MAX_DIGITS     5   digits accepted per entry; further digits ignored
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  kp_row       in   4   keypad rows, active-low (pulled up); asynchronous, 2-FF synchronised internally
//  kp_col       out  4   column drive, active-low, exactly one bit low at all times
//  key_code     out  4   code of the last accepted key (0-9 digits, A-D = 4'hA-4'hD, '*' = 4'hE, '#' = 4'hF)
//  key_pulse    out  1   1-cycle strobe, key accepted
//  entry_value  out  16  number being typed (binary)
//  value_out    out  16  last committed number
//  value_valid  out  1   1-cycle strobe, value_out updated
//  overflow     out  1   sticky: entry saturated at 65535; cleared by '*', '#' or reset
// BEHAVIOUR
//  Reset: kp_col=4'b1110, column index 0, dwell counter 0, FSM IDLE; all other outputs 0.
//  Scan: dwell counter counts to 2**SCAN_BITS-1; sample synchronised rows on the last dwell cycle, then advance column 0->1->2->3->0.
//  Key map (row r, col c): r0 "1 2 3 A", r1 "4 5 6 B", r2 "7 8 9 C", r3 "* 0 # D".
//  Scan result at column-3 sample: exactly one key down -> that code; zero keys -> NONE; two or more -> NONE (ghost reject).
//  Debounce FSM, evaluated once per scan end:
//   IDLE:    result!=NONE -> CAND (cand=result, cnt=1)
//   CAND:    result==cand -> cnt+1; cnt reaching DEBOUNCE_SCANS -> PRESSED, accept; result!=cand -> IDLE
//   PRESSED: result==NONE -> RELEASE (cnt=1); anything else stays PRESSED (a new key needs release first)
//   RELEASE: NONE -> cnt+1, reaching DEBOUNCE_SCANS -> IDLE; result!=NONE -> PRESSED
//  Accept: on the cycle after the accepting scan end, key_pulse=1, key_code=cand, and the action below is applied in that same cycle.
//  Actions:
//   digit d:  if digits<MAX_DIGITS: sum = entry*10+d in 20 bits; sum>65535 -> entry=65535, overflow=1;
//             else entry=sum; digits+1 (leading zeros count as digits). At MAX_DIGITS: ignored, but key_pulse still fires.
//   '#':      if digits>0: value_out=entry, value_valid=1 (same cycle as key_pulse), entry=0, digits=0, overflow=0;
//             if digits==0: no commit.
//   '*':      entry=0, digits=0, overflow=0, no commit.
//   A-D:      key_pulse only, entry unchanged.
//  Latency: press stable from a scan start -> key_pulse after DEBOUNCE_SCANS full scans + <=3 cycles (sync + register).
//  Reset mid-operation: everything returns to reset values; a key still held afterwards is reported again after a normal debounce.
//  value_out holds its value until the next commit; value_valid never asserts on two consecutive cycles.
// STRUCTURE
//  keypad_pkg:      key code constants (KEY_STAR=4'hE, KEY_HASH=4'hF), KEY_NONE sentinel (5-bit result w/ valid bit),
//                   debounce state enum, keymap table.
//  keypad_debounce: sub-module holding the debounce FSM + counter; in: scan_end, result; out: accept, code.
//  Top: column scanner, row synchroniser, per-scan collector, entry accumulator (x10 = (x<<3)+(x<<1)).
// TESTING (bench uses SCAN_BITS=2, DEBOUNCE_SCANS=4; keypad model pulls row r low while col c is driven low and key (r,c) is held)
//  Press/release 1,2,3,# in turn -> 4 key_pulses; entry_value 1,12,123, then value_out=123, value_valid 1 cycle, entry_value=0.
//  Key 5 bouncing (toggled every scan for 3 scans), then held stable -> exactly one key_pulse code 5, entry_value=5.
//  9 x5 -> entry_value 65535, overflow=1; 6th '9' -> key_pulse, value unchanged; '#' -> value_out=65535, overflow=0.
//  Hold 4 and 6 together -> no pulse; release 6 -> key_pulse code 4 after 4 clean scans; release 4 -> no pulse.
//  4,5,'*' -> entry_value 0, no value_valid; '#' with empty entry -> key_pulse code F, no value_valid.
//  Assert reset while 7 is held mid-debounce -> all outputs 0, kp_col=1110; 7 reported once after reset release + 4 scans.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad entry block: key codes, scan-result
// encoding, debounce states and the row/column keymap.
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Scan result: bit 4 = exactly one key seen, bits 3:0 = its code.
  localparam logic [4:0] KEY_NONE = 5'b0_0000;

  typedef enum logic [1:0] {StIdle, StCand, StPressed, StRelease} db_state_e;

  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = KEY_STAR;
      4'd13:   code = 4'h0;
      4'd14:   code = KEY_HASH;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounce FSM: a key must appear in DEBOUNCE_SCANS consecutive scan results to be accepted,
// and the pad must read empty for as many scans before another key can be accepted.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_end,
  input  logic [4:0] result,
  output logic       accept,
  output logic [3:0] code
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CntW-1:0] CntDone = CntW'(DEBOUNCE_SCANS);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  db_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      cand_q, cand_d;
  logic            accept_q, accept_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    accept_d = 1'b0;
    if (scan_end) begin
      unique case (state_q)
        StIdle: begin
          if (result[4]) begin
            state_d = StCand;
            cand_d  = result[3:0];
            cnt_d   = CntOne;
          end
        end
        StCand: begin
          if (result == {1'b1, cand_q}) begin
            if (cnt_q + CntOne == CntDone) begin
              state_d  = StPressed;
              accept_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CntOne;
            end
          end else begin
            state_d = StIdle;
          end
        end
        StPressed: begin
          if (!result[4]) begin
            state_d = StRelease;
            cnt_d   = CntOne;
          end
        end
        StRelease: begin
          if (!result[4]) begin
            if (cnt_q + CntOne == CntDone) state_d = StIdle;
            else cnt_d = cnt_q + CntOne;
          end else begin
            state_d = StPressed;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      cand_q   <= '0;
      accept_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      accept_q <= accept_d;
    end
  end

  assign accept = accept_q;
  assign code   = cand_q;

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad front end: column scan, row sync, per-scan ghost-rejecting collector, debounce,
// and a decimal entry accumulator with commit ('#') and clear ('*').
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_BITS      = 18,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned MAX_DIGITS     = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  kp_row,
  output logic [3:0]  kp_col,
  output logic [3:0]  key_code,
  output logic        key_pulse,
  output logic [15:0] entry_value,
  output logic [15:0] value_out,
  output logic        value_valid,
  output logic        overflow
);

  localparam int unsigned DigW = $clog2(MAX_DIGITS + 1);

  logic [SCAN_BITS-1:0] dwell_q, dwell_d;
  logic [1:0]           col_q, col_d;
  logic [3:0]           kp_col_q, kp_col_d;
  logic [3:0]           row_s1_q, row_s2_q;
  logic [1:0]           hits_q, hits_d, hits_c;
  logic [3:0]           hit_code_q, hit_code_d, code_c;
  logic [4:0]           result_q, result_d;
  logic                 scan_end_q, scan_end_d;

  logic                 acc_accept;
  logic [3:0]           acc_code;

  logic                 key_pulse_q, key_pulse_d;
  logic [3:0]           key_code_q, key_code_d;
  logic [15:0]          entry_q, entry_d;
  logic [DigW-1:0]      digits_q, digits_d;
  logic [15:0]          value_q, value_d;
  logic                 value_valid_q, value_valid_d;
  logic                 overflow_q, overflow_d;
  logic [19:0]          sum;

  // Scanner and collector; rows are read on the last dwell cycle so the 2-FF sync has settled.
  always_comb begin
    dwell_d    = dwell_q + 1'b1;
    col_d      = col_q;
    kp_col_d   = kp_col_q;
    hits_d     = hits_q;
    hit_code_d = hit_code_q;
    result_d   = result_q;
    scan_end_d = 1'b0;
    hits_c     = hits_q;
    code_c     = hit_code_q;
    if (&dwell_q) begin
      col_d    = col_q + 2'd1;
      kp_col_d = ~(4'b0001 << col_d);
      for (int r = 0; r < 4; r++) begin
        if (!row_s2_q[r]) begin
          if (hits_c != 2'd2) hits_c = hits_c + 2'd1;
          code_c = keymap(2'(r), col_q);
        end
      end
      if (col_q == 2'd3) begin
        result_d   = (hits_c == 2'd1) ? {1'b1, code_c} : KEY_NONE;
        scan_end_d = 1'b1;
        hits_d     = '0;
        hit_code_d = '0;
      end else begin
        hits_d     = hits_c;
        hit_code_d = code_c;
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .scan_end (scan_end_q),
    .result   (result_q),
    .accept   (acc_accept),
    .code     (acc_code)
  );

  always_comb begin
    key_pulse_d   = acc_accept;
    key_code_d    = acc_accept ? acc_code : key_code_q;
    entry_d       = entry_q;
    digits_d      = digits_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    overflow_d    = overflow_q;
    sum = ({4'b0, entry_q} << 3) + ({4'b0, entry_q} << 1) + {16'b0, acc_code};
    if (acc_accept) begin
      if (acc_code <= 4'd9) begin
        if (digits_q < DigW'(MAX_DIGITS)) begin
          digits_d = digits_q + 1'b1;
          if (sum > 20'd65535) begin
            entry_d    = 16'hFFFF;
            overflow_d = 1'b1;
          end else begin
            entry_d = sum[15:0];
          end
        end
      end else if (acc_code == KEY_HASH) begin
        overflow_d = 1'b0;
        if (digits_q != '0) begin
          value_d       = entry_q;
          value_valid_d = 1'b1;
          entry_d       = '0;
          digits_d      = '0;
        end
      end else if (acc_code == KEY_STAR) begin
        entry_d    = '0;
        digits_d   = '0;
        overflow_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_q       <= '0;
      col_q         <= '0;
      kp_col_q      <= 4'b1110;
      row_s1_q      <= 4'hF;
      row_s2_q      <= 4'hF;
      hits_q        <= '0;
      hit_code_q    <= '0;
      result_q      <= KEY_NONE;
      scan_end_q    <= 1'b0;
      key_pulse_q   <= 1'b0;
      key_code_q    <= '0;
      entry_q       <= '0;
      digits_q      <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      dwell_q       <= dwell_d;
      col_q         <= col_d;
      kp_col_q      <= kp_col_d;
      row_s1_q      <= kp_row;
      row_s2_q      <= row_s1_q;
      hits_q        <= hits_d;
      hit_code_q    <= hit_code_d;
      result_q      <= result_d;
      scan_end_q    <= scan_end_d;
      key_pulse_q   <= key_pulse_d;
      key_code_q    <= key_code_d;
      entry_q       <= entry_d;
      digits_q      <= digits_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      overflow_q    <= overflow_d;
    end
  end

  assign kp_col      = kp_col_q;
  assign key_code    = key_code_q;
  assign key_pulse   = key_pulse_q;
  assign entry_value = entry_q;
  assign value_out   = value_q;
  assign value_valid = value_valid_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: a matrix keypad model, a directed vector table,
// hand-written corner sequences and random key streams checked against an entry model.
module tb_keypad_entry;

  localparam int ScanCyc = 16;  // 4 columns x 2**2 dwell cycles
  localparam int Hold    = 7;   // scans a key is held, and then released, per press

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  kp_row, kp_col, key_code;
  logic        key_pulse, value_valid, overflow;
  logic [15:0] entry_value, value_out;

  logic [15:0] held = '0;  // bit r*4+c set while key (r,c) is down
  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  int vv_cnt = 0;
  logic [3:0] last_code = '0;
  logic vv_prev = 1'b0;

  int m_entry, m_digits, m_value;
  bit m_ov;

  logic [3:0] tb_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  typedef struct {
    logic [3:0]  key;
    logic [15:0] entry;
    logic        ov;
    logic        commit;
    logic [15:0] value;
  } vec_t;
  vec_t vecs [16];

  keypad_entry #(
    .SCAN_BITS      (2),
    .DEBOUNCE_SCANS (4),
    .MAX_DIGITS     (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .kp_row      (kp_row),
    .kp_col      (kp_col),
    .key_code    (key_code),
    .key_pulse   (key_pulse),
    .entry_value (entry_value),
    .value_out   (value_out),
    .value_valid (value_valid),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always_comb begin
    kp_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !kp_col[c]) kp_row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      vv_prev = 1'b0;
    end else begin
      if (key_pulse) begin
        pulse_cnt++;
        last_code = key_code;
      end
      if (value_valid) begin
        vv_cnt++;
        check("vv_back_to_back", {31'b0, vv_prev}, 0);
        check("vv_with_key_pulse", {31'b0, key_pulse}, 1);
      end
      vv_prev = value_valid;
    end
  end

  function automatic int pos_of(input logic [3:0] code);
    for (int i = 0; i < 16; i++) if (tb_map[i] == code) return i;
    return 0;
  endfunction

  task automatic wait_scans(input int n);
    repeat (n * ScanCyc) @(posedge clk);
    #1;
  endtask

  task automatic set_key(input logic [3:0] code, input logic down);
    held[pos_of(code)] = down;
  endtask

  task automatic press(input logic [3:0] code);
    set_key(code, 1'b1);
    wait_scans(Hold);
    set_key(code, 1'b0);
    wait_scans(Hold);
  endtask

  task automatic model_reset();
    m_entry = 0; m_digits = 0; m_value = 0; m_ov = 0;
  endtask

  // Entry rules in plain integer arithmetic.
  task automatic model_key(input logic [3:0] code, output bit commit);
    commit = 0;
    if (code <= 4'd9) begin
      if (m_digits < 5) begin
        m_digits++;
        m_entry = m_entry * 10 + int'(code);
        if (m_entry > 65535) begin m_entry = 65535; m_ov = 1; end
      end
    end else if (code == 4'hF) begin
      m_ov = 0;
      if (m_digits > 0) begin
        commit = 1; m_value = m_entry; m_entry = 0; m_digits = 0;
      end
    end else if (code == 4'hE) begin
      m_entry = 0; m_digits = 0; m_ov = 0;
    end
  endtask

  task automatic check_model(input string tag, input int p0, input int v0,
                             input logic [3:0] code, input bit commit);
    check({tag, "_pulses"}, pulse_cnt - p0, 1);
    check({tag, "_code"}, {28'b0, last_code}, {28'b0, code});
    check({tag, "_commit"}, vv_cnt - v0, {31'b0, commit});
    check({tag, "_entry"}, {16'b0, entry_value}, m_entry);
    check({tag, "_overflow"}, {31'b0, overflow}, {31'b0, m_ov});
    check({tag, "_value_out"}, {16'b0, value_out}, m_value);
  endtask

  initial begin
    int  p0, v0;
    bit  commit;
    logic [3:0] k;

    vecs = '{
      '{4'h1, 16'd1,     1'b0, 1'b0, 16'd0},
      '{4'h2, 16'd12,    1'b0, 1'b0, 16'd0},
      '{4'h3, 16'd123,   1'b0, 1'b0, 16'd0},
      '{4'hF, 16'd0,     1'b0, 1'b1, 16'd123},
      '{4'h9, 16'd9,     1'b0, 1'b0, 16'd123},
      '{4'h9, 16'd99,    1'b0, 1'b0, 16'd123},
      '{4'h9, 16'd999,   1'b0, 1'b0, 16'd123},
      '{4'h9, 16'd9999,  1'b0, 1'b0, 16'd123},
      '{4'h9, 16'd65535, 1'b1, 1'b0, 16'd123},
      '{4'h9, 16'd65535, 1'b1, 1'b0, 16'd123},
      '{4'hF, 16'd0,     1'b0, 1'b1, 16'd65535},
      '{4'h4, 16'd4,     1'b0, 1'b0, 16'd65535},
      '{4'h5, 16'd45,    1'b0, 1'b0, 16'd65535},
      '{4'hE, 16'd0,     1'b0, 1'b0, 16'd65535},
      '{4'hF, 16'd0,     1'b0, 1'b0, 16'd65535},
      '{4'hA, 16'd0,     1'b0, 1'b0, 16'd65535}
    };

    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_kp_col", {28'b0, kp_col}, 32'hE);
    check("rst_key_code", {28'b0, key_code}, 0);
    check("rst_key_pulse", {31'b0, key_pulse}, 0);
    check("rst_entry", {16'b0, entry_value}, 0);
    check("rst_value_out", {16'b0, value_out}, 0);
    check("rst_value_valid", {31'b0, value_valid}, 0);
    check("rst_overflow", {31'b0, overflow}, 0);
    reset = 1'b0;
    wait_scans(2);

    // Directed table
    for (int i = 0; i < 16; i++) begin
      p0 = pulse_cnt; v0 = vv_cnt;
      press(vecs[i].key);
      model_key(vecs[i].key, commit);
      check("vec_pulses", pulse_cnt - p0, 1);
      check("vec_code", {28'b0, last_code}, {28'b0, vecs[i].key});
      check("vec_commit", vv_cnt - v0, {31'b0, vecs[i].commit});
      check("vec_entry", {16'b0, entry_value}, {16'b0, vecs[i].entry});
      check("vec_overflow", {31'b0, overflow}, {31'b0, vecs[i].ov});
      check("vec_value_out", {16'b0, value_out}, {16'b0, vecs[i].value});
    end

    // Bouncing 5: on/off/on one scan each, then held stable
    p0 = pulse_cnt; v0 = vv_cnt;
    set_key(4'h5, 1'b1); wait_scans(1);
    set_key(4'h5, 1'b0); wait_scans(1);
    set_key(4'h5, 1'b1); wait_scans(1);
    wait_scans(Hold);
    set_key(4'h5, 1'b0);
    wait_scans(Hold);
    model_key(4'h5, commit);
    check_model("bounce", p0, v0, 4'h5, commit);

    // Two keys in one row are a ghost; releasing one lets the other through
    p0 = pulse_cnt; v0 = vv_cnt;
    set_key(4'h4, 1'b1);
    set_key(4'h6, 1'b1);
    wait_scans(Hold);
    check("ghost_no_pulse", pulse_cnt - p0, 0);
    set_key(4'h6, 1'b0);
    wait_scans(Hold);
    model_key(4'h4, commit);
    check_model("ghost_release", p0, v0, 4'h4, commit);
    p0 = pulse_cnt;
    set_key(4'h4, 1'b0);
    wait_scans(Hold);
    check("ghost_final_release", pulse_cnt - p0, 0);

    // Reset while 7 is mid-debounce
    set_key(4'h7, 1'b1);
    wait_scans(2);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_kp_col", {28'b0, kp_col}, 32'hE);
    check("mid_rst_outputs", {26'b0, key_code, key_pulse, value_valid},  0);
    check("mid_rst_entry", {16'b0, entry_value}, 0);
    check("mid_rst_value_out", {16'b0, value_out}, 0);
    check("mid_rst_overflow", {31'b0, overflow}, 0);
    model_reset();
    p0 = pulse_cnt; v0 = vv_cnt;
    reset = 1'b0;
    wait_scans(Hold);
    set_key(4'h7, 1'b0);
    wait_scans(Hold);
    model_key(4'h7, commit);
    check_model("post_rst", p0, v0, 4'h7, commit);

    // Random key stream, digit-weighted
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) k = 4'($urandom_range(0, 9));
      else k = 4'($urandom_range(0, 15));
      p0 = pulse_cnt; v0 = vv_cnt;
      press(k);
      model_key(k, commit);
      check_model("rand", p0, v0, k, commit);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
